// File: rtl/mem_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter2
// Purpose  : Two-port round-robin arbiter in front of the single-port 8-bit
//            system RAM. Port 0 is the CPU core, port 1 the DMA/loader.
//            One command is accepted per cycle and issued as a registered
//            mem_* command. Read data is captured at the end of the access
//            cycle and returned to the winning port one cycle later.
//            A per-port lock keeps the bus across multi-access sequences.
// Ports    : clk, rst (async, active-low)
//            req/we/lock/addr/wdata 0|1  - requester command inputs
//            gnt 0|1                     - command accepted (1-cycle pulse)
//            rvalid/rdata 0|1            - read return (rdata holds value)
//            mem_en/mem_we/mem_a/mem_wd  - registered memory command
//            mem_rd                      - memory read data (comb. of mem_a)
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter2 #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  // State encodes {locked, owner}; the owner bit is irrelevant while FREE.
  typedef enum logic [1:0] {
    FREE  = 2'b00,
    LOCK0 = 2'b10,
    LOCK1 = 2'b11
  } state_t;

  state_t state, state_next;
  logic   last;      // last-granted port; reset to 1 so port 0 wins first tie
  logic   rd_pend;   // a read access is on the memory bus this cycle
  logic   rd_port;   // which port that read belongs to
  logic   grant0, grant1;

  // Arbitration and lock tracking
  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    state_next = state;
    case (state)
      // While locked only the owner may be granted, even if it is idle.
      LOCK0: grant0 = req0;
      LOCK1: grant1 = req1;
      default: begin
        if (req0 && req1) begin
          grant0 = last;
          grant1 = ~last;
        end else begin
          grant0 = req0;
          grant1 = req1;
        end
      end
    endcase
    if (grant0) begin
      state_next = lock0 ? LOCK0 : FREE;
    end else if (grant1) begin
      state_next = lock1 ? LOCK1 : FREE;
    end
  end

  // Command register, grant pulses and read return
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FREE;
      last    <= 1'b1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      mem_a   <= '0;
      mem_wd  <= '0;
      rd_pend <= 1'b0;
      rd_port <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      state  <= state_next;
      gnt0   <= grant0;
      gnt1   <= grant1;
      mem_en <= grant0 | grant1;
      mem_we <= (grant0 & we0) | (grant1 & we1);
      // Address and data hold their last value when idle.
      if (grant0) begin
        mem_a  <= addr0;
        mem_wd <= wdata0;
        last   <= 1'b0;
      end else if (grant1) begin
        mem_a  <= addr1;
        mem_wd <= wdata1;
        last   <= 1'b1;
      end
      rd_pend <= (grant0 & ~we0) | (grant1 & ~we1);
      rd_port <= grant1;
      // mem_rd reflects the read address issued this cycle; capture it at
      // the edge that ends the access and flag it valid for one cycle.
      rvalid0 <= rd_pend & ~rd_port;
      rvalid1 <= rd_pend & rd_port;
      if (rd_pend) begin
        if (rd_port) begin
          rdata1 <= mem_rd;
        end else begin
          rdata0 <= mem_rd;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter2
// Purpose  : Self-checking bench for mem_arbiter2 with a behavioural RAM.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter2;

  logic        clk;
  logic        rst;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0]  rdata0, rdata1;
  logic        mem_en, mem_we;
  logic [15:0] mem_a;
  logic [7:0]  mem_wd, mem_rd;

  mem_arbiter2 #(.AW(16), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: combinational read, write on posedge.
  logic [7:0] ram [0:65535];
  logic       preload;
  assign mem_rd = ram[mem_a];
  always @(posedge clk) begin
    if (preload) begin
      ram[16'h0103] <= 8'hA5;
      ram[16'h0002] <= 8'h11;
      ram[16'h0007] <= 8'h00;
    end else if (mem_en && mem_we) begin
      ram[mem_a] <= mem_wd;
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_ctl"}, {58'd0, gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we}, 64'd0);
    chk({name, "_rdata"}, {48'd0, rdata0, rdata1}, 64'd0);
    chk({name, "_mem"}, {40'd0, mem_a, mem_wd}, 64'd0);
  endtask

  // ctl = {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we}
  typedef struct packed {
    logic        r0, w0, l0;
    logic [15:0] a0;
    logic [7:0]  d0;
    logic        r1, w1, l1;
    logic [15:0] a1;
    logic [7:0]  d1;
    logic [5:0]  ctl;
    logic [7:0]  rd0, rd1;
    logic [15:0] ma;
    logic [7:0]  mwd;
  } vec_t;

  task automatic clear_in();
    req0 = 0; we0 = 0; lock0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; lock1 = 0; addr1 = '0; wdata1 = '0;
  endtask

  vec_t vt [10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    //        r0 w0 l0 a0       d0     r1 w1 l1 a1       d1     ctl        rd0    rd1    ma       mwd
    vt[0] = {1'b0,1'b0,1'b0,16'h0000,8'h00,1'b0,1'b0,1'b0,16'h0000,8'h00,6'b000000,8'h00,8'h00,16'h0000,8'h00};
    vt[1] = {1'b1,1'b0,1'b0,16'h0103,8'h00,1'b0,1'b0,1'b0,16'h0000,8'h00,6'b100010,8'h00,8'h00,16'h0103,8'h00};
    vt[2] = {1'b0,1'b0,1'b0,16'h0000,8'h00,1'b0,1'b0,1'b0,16'h0000,8'h00,6'b001000,8'hA5,8'h00,16'h0000,8'h00};
    vt[3] = {1'b0,1'b0,1'b0,16'h0000,8'h00,1'b1,1'b1,1'b0,16'h0007,8'h3C,6'b010011,8'hA5,8'h00,16'h0007,8'h3C};
    vt[4] = {1'b0,1'b0,1'b0,16'h0000,8'h00,1'b1,1'b0,1'b0,16'h0007,8'h3C,6'b010010,8'hA5,8'h00,16'h0007,8'h3C};
    vt[5] = {1'b0,1'b0,1'b0,16'h0000,8'h00,1'b0,1'b0,1'b0,16'h0000,8'h00,6'b000100,8'hA5,8'h3C,16'h0000,8'h00};
    vt[6] = {1'b0,1'b0,1'b0,16'h0000,8'h00,1'b0,1'b0,1'b0,16'h0000,8'h00,6'b000000,8'hA5,8'h3C,16'h0000,8'h00};
    vt[7] = {1'b1,1'b0,1'b0,16'h0103,8'h00,1'b1,1'b0,1'b0,16'h0002,8'h00,6'b100010,8'hA5,8'h3C,16'h0103,8'h00};
    vt[8] = {1'b0,1'b0,1'b0,16'h0000,8'h00,1'b1,1'b0,1'b0,16'h0002,8'h00,6'b011010,8'hA5,8'h3C,16'h0002,8'h00};
    vt[9] = {1'b0,1'b0,1'b0,16'h0000,8'h00,1'b0,1'b0,1'b0,16'h0000,8'h00,6'b000100,8'hA5,8'h11,16'h0000,8'h00};

    clear_in();
    rst = 1'b0;
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    @(negedge clk);
    chk_reset("reset");
    rst = 1'b1;

    // Table-driven: inputs applied at a negedge, outputs checked at the next.
    for (int i = 0; i < 10; i++) begin
      req0 = vt[i].r0; we0 = vt[i].w0; lock0 = vt[i].l0; addr0 = vt[i].a0; wdata0 = vt[i].d0;
      req1 = vt[i].r1; we1 = vt[i].w1; lock1 = vt[i].l1; addr1 = vt[i].a1; wdata1 = vt[i].d1;
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), {58'd0, gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we},
          {58'd0, vt[i].ctl});
      chk($sformatf("vec%0d_rdata", i), {48'd0, rdata0, rdata1}, {48'd0, vt[i].rd0, vt[i].rd1});
      if (vt[i].ctl[1])
        chk($sformatf("vec%0d_mem", i), {40'd0, mem_a, mem_wd}, {40'd0, vt[i].ma, vt[i].mwd});
    end
    clear_in();

    // Contention straight out of reset: 0,1,0,1,0,1.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req0 = 1; addr0 = 16'h0103;
    req1 = 1; addr1 = 16'h0002;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("contend_gnt%0d", i), {62'd0, gnt0, gnt1}, (i % 2 == 0) ? 64'd2 : 64'd1);
    end
    clear_in();
    @(negedge clk);
    chk("contend_rd1", {54'd0, rvalid0, rvalid1, rdata1}, {54'd0, 1'b0, 1'b1, 8'h11});

    // Lock: port 1 holds the bus for three accesses; port 0 waits.
    req1 = 1; lock1 = 1; addr1 = 16'h0010;
    @(negedge clk);
    chk("lock_g1", {62'd0, gnt0, gnt1}, 64'd1);
    req0 = 1; addr0 = 16'h0103;
    @(negedge clk);
    chk("lock_g2", {62'd0, gnt0, gnt1}, 64'd1);
    req1 = 0;
    @(negedge clk);
    chk("lock_idle_hold", {62'd0, gnt0, gnt1}, 64'd0);
    req1 = 1; lock1 = 0;
    @(negedge clk);
    chk("lock_g3", {62'd0, gnt0, gnt1}, 64'd1);
    req1 = 0;
    @(negedge clk);
    chk("lock_release_g0", {62'd0, gnt0, gnt1}, 64'd2);
    clear_in();
    @(negedge clk);

    // Reset during a write cycle: the write must not commit.
    req0 = 1; we0 = 1; addr0 = 16'h0002; wdata0 = 8'h99;
    @(negedge clk);
    chk("rstwr_cmd", {46'd0, mem_en, mem_we, mem_a}, {46'd0, 1'b1, 1'b1, 16'h0002});
    clear_in();
    rst = 1'b0;
    #1;
    chk_reset("rstwr");
    @(negedge clk);
    chk("rstwr_ram", {56'd0, ram[16'h0002]}, {56'd0, 8'h11});
    rst = 1'b1;

    // Reset during a read cycle: the read is discarded.
    req1 = 1; addr1 = 16'h0103;
    @(negedge clk);
    chk("rstrd_gnt", {62'd0, gnt0, gnt1}, 64'd1);
    clear_in();
    rst = 1'b0;
    #1;
    chk_reset("rstrd_now");
    @(negedge clk);
    chk_reset("rstrd_next");
    rst = 1'b1;
    @(negedge clk);
    chk("rstrd_norv", {62'd0, rvalid0, rvalid1}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter2.md
# mem_arbiter2

Two-port round-robin arbiter that shares the single-port 8-bit system RAM between the CPU core (port 0) and a DMA/loader master (port 1). It sits between the requesters and the RAM: it accepts one command per cycle, drives registered address, write-enable and write-data to the memory, and returns captured read data to the winning port. A lock input lets a port hold the bus across multi-access sequences, for example read-modify-write.

## Interface
- AW, 16, address width
- DW, 8, data width
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- req0 / req1  in  1  access request, port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read; qualified by reqN
- lock0 / lock1  in  1  keep ownership after this access; qualified by reqN
- addr0 / addr1  in  AW  access address
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  one-cycle pulse: command accepted
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdataN valid
- rdata0 / rdata1  out  DW  read data; holds its value until the next rvalid
- mem_en  out  1  memory access cycle
- mem_we  out  1  memory write strobe; the RAM commits on the posedge ending the cycle
- mem_a  out  AW  memory address
- mem_wd  out  DW  memory write data; tristating onto the shared bus is done outside this block
- mem_rd  in  DW  memory read data; combinational from mem_a

## Operation
- Registers:
  - owner (1 bit)
  - locked (1 bit)
  - last (1 bit, the last-granted port)
  - the mem_* command register
  - the read-return tag: rd_pend and rd_port
- Arbitration, evaluated on each posedge:
  - If locked: only the owner's req is eligible. The other port waits even if the owner is idle.
  - Otherwise, with a single req, that port wins.
  - Otherwise, with both reqs, the port != last wins.
  - No eligible req: no grant, mem_en = 0, mem_we = 0.
- On grant to port p:
  - gnt_p = 1 for one cycle.
  - mem_a <= addr_p, mem_wd <= wdata_p, mem_we <= we_p, mem_en <= 1.
  - last <= p, owner <= p, locked <= lock_p.
  - On a read: rd_pend <= 1 and rd_port <= p.
- Lock release: the owner's next granted access with lock_p = 0 clears locked. That access is still performed.
- Read return:
  - On the posedge ending a read access cycle, mem_rd is captured into rdata[rd_port].
  - rvalid[rd_port] pulses the following cycle.
  - rdata of the other port is unchanged.
- Writes produce no rvalid.
- Requester rule: keep reqN, weN, addrN, wdataN and lockN stable until gntN is seen. After gnt they may change, and a new request may be presented in the same cycle gnt is high.
- Back-to-back: one access per cycle, sustained. Two requesters that both hold req alternate 0, 1, 0, 1.
- States, encoded by owner and locked: FREE, LOCK0, LOCK1.
  - FREE -> LOCKp on a grant with lock_p = 1.
  - LOCKp -> FREE on a grant to p with lock_p = 0.
- Address and data pass through unmodified; there is no width conversion and no wrap handling. Zero-page decode remains in the memory.

## Timing
- Reset values: gnt0 = gnt1 = 0, rvalid0 = rvalid1 = 0, rdata0 = rdata1 = 0, mem_en = mem_we = 0, mem_a = 0, mem_wd = 0.
- Internal reset values: owner = 0, locked = 0, last = 1, so port 0 wins the first tie.
- Cycle N: reqN is sampled at the posedge ending N.
- Cycle N+1: gnt is high and the mem_* command is driven.
- Writes commit at the posedge ending N+1.
- Cycle N+2: rvalid is high and rdata is valid. Request-to-data latency is 2 cycles.
- Reset asserted mid-operation:
  - All outputs are forced to reset values immediately, including mem_we, so no write commits on the following edge.
  - A pending read is discarded, with no rvalid.
  - Any lock is cleared.
- Reset deassertion takes effect synchronously: the first grant is possible at the first posedge after rst rises.
- req deasserted before grant: the request is withdrawn and has no effect.

## Test plan
- Single read: port 0 reads 0x0103 with the RAM holding 0xA5 there. Expect gnt0 one cycle after req, mem_a = 0x0103, mem_we = 0, then rvalid0 = 1 with rdata0 = 0xA5 one cycle later. rdata1 stays 0.
- Write then read: port 1 writes 0x3C to 0x0007, then reads 0x0007. Expect mem_we = 1 for exactly one cycle, then rvalid1 with rdata1 = 0x3C. There is no rvalid for the write.
- Contention, both reqs held for 6 cycles starting right after reset: grant order is 0, 1, 0, 1, 0, 1, with exactly one gnt per cycle.
- Lock:
  - Port 1 issues 3 accesses; the first two have lock1 = 1 and the third has lock1 = 0. Port 0 requests throughout.
  - Expect no gnt0 until the posedge after the third gnt1, then gnt0.
  - A single idle owner cycle during the lock still blocks port 0.
- Reset mid-write: assert rst while mem_we = 1 to address 0x0002, which holds 0x11. Expect mem_we = 0 immediately and 0x0002 still holding 0x11.
- Reset mid-read: assert rst during a read access. Expect no rvalid and all outputs at reset values.
